vga_mode_ctrl: RTL and testbench
================================

VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4, number of valid entries in the package mode table.
REQ-002 SHALL have parameter RESET_MODE, default 0, mode programmed after reset.
REQ-003 SHALL have parameter WDOG_CYCLES, default 2**22, cycles without a frame boundary before a forced load.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port arstn_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode_i  in  2  requested mode index.
REQ-007 SHALL have port mode_req_i  in  1  request valid, held until mode_ack_o.
REQ-008 SHALL have port mode_ack_o  out  1  one-cycle acknowledge.
REQ-009 SHALL have port mode_err_o  out  1  qualifies mode_ack_o: request rejected.
REQ-010 SHALL have port busy_o  out  1  high in any state other than IDLE.
REQ-011 SHALL have ports hcount_i / vcount_i  in  VGA_MAX_H_WIDTH / VGA_MAX_V_WIDTH  live counters from the timing generator.
REQ-012 SHALL have ports hd_o, hf_o, hr_o, hb_o  out  VGA_MAX_H_WIDTH each  horizontal timing fields.
REQ-013 SHALL have ports vd_o, vf_o, vr_o, vb_o  out  VGA_MAX_V_WIDTH each  vertical timing fields.
REQ-014 SHALL have port we_o  out  1  one-cycle write strobe to the timing generator.
REQ-015 SHALL have port cur_mode_o  out  2  mode currently programmed.

Function
REQ-016 SHALL implement FSM states INIT, IDLE, WAIT_FRAME, LOAD, ACK.
REQ-017 INIT: entered from reset; the first cycle drives we_o=1 with the RESET_MODE fields; the next state is IDLE.
REQ-018 IDLE with mode_req_i=1: mode_i >= NUM_MODES -> ACK with mode_err_o=1; mode_i == cur_mode_o -> ACK with no load and mode_err_o=0; otherwise latch mode_i as pending and go to WAIT_FRAME.
REQ-019 SHALL compute hmax_cur/vmax_cur as the sum of the current fields minus 1, widths per package, no overflow for table entries.
REQ-020 WAIT_FRAME: at the edge where hcount_i==hmax_cur-1 and vcount_i==vmax_cur, register the pending fields onto the outputs, update cur_mode_o, and enter LOAD.
REQ-021 LOAD: lasts exactly one cycle; we_o=1, which coincides with hcount_i==hmax_cur, vcount_i==vmax_cur (the last pixel of the frame); the next state is ACK.
REQ-022 Effect of LOAD: the new timing takes effect as the counters wrap to 0, so no partial frame occurs.
REQ-023 Watchdog: a counter runs in WAIT_FRAME only; reaching WDOG_CYCLES-1 forces the REQ-020 load regardless of the counts (recovers from a desynchronised generator); the counter clears on exit.
REQ-024 ACK: mode_ack_o=1 for one cycle; the next state is IDLE; mode_req_i is ignored in ACK.
REQ-025 mode_i SHALL be sampled only in IDLE; changes while busy SHALL be ignored.
REQ-026 we_o SHALL be high only in INIT and LOAD, never two consecutive cycles.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On arstn_i low: state=INIT; fields and cur_mode_o=RESET_MODE entry; we_o, mode_ack_o, mode_err_o, busy_o=0; watchdog=0; pending mode=RESET_MODE.
REQ-029 Reset asserted mid-WAIT_FRAME or LOAD SHALL discard the pending request with no ack.

Structure
REQ-030 vga_pkg SHALL hold the vga_timing_t struct (eight fields, package widths) and the VGA_MODES table: 0=640x480 (640,16,96,48 / 480,10,2,33); 1=800x600 (800,40,128,88 / 600,1,4,23); 2=1024x768 (1024,24,136,160 / 768,3,6,29); 3=sim (8,2,2,2 / 4,1,1,1).
REQ-031 SHALL contain one sub-module, vga_mode_rom, a combinational index-to-vga_timing_t lookup.

Verification
REQ-032 Reset release, RESET_MODE=3 -> we_o high for exactly the first cycle; outputs 8,2,2,2/4,1,1,1; busy_o then 0.
REQ-033 Mode 3 running, request mode 0 -> we_o pulses while hcount_i=13, vcount_i=6; outputs 640,16,96,48/480,10,2,33; mode_ack_o the next cycle; cur_mode_o=0.
REQ-034 Request mode_i=3 while cur_mode_o=3 -> mode_ack_o after 1 cycle, no we_o, mode_err_o=0.
REQ-035 NUM_MODES=3, request mode 3 -> mode_ack_o with mode_err_o=1; fields unchanged.
REQ-036 WDOG_CYCLES=64, hcount_i held at 0 -> we_o fires 64 cycles after WAIT_FRAME entry, then ack.
REQ-037 Reset pulsed two cycles into WAIT_FRAME -> no ack; INIT reprograms RESET_MODE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and the fixed video-mode table for the VGA mode controller.
// Field widths are sized so the largest total (1344 x 806) fits without overflow.
package vga_pkg;

  localparam int VGA_MAX_H_WIDTH = 11;
  localparam int VGA_MAX_V_WIDTH = 10;
  localparam int VGA_MODE_W      = 2;
  localparam int VGA_TABLE_SIZE  = 4;

  typedef struct packed {
    logic [VGA_MAX_H_WIDTH-1:0] hd;
    logic [VGA_MAX_H_WIDTH-1:0] hf;
    logic [VGA_MAX_H_WIDTH-1:0] hr;
    logic [VGA_MAX_H_WIDTH-1:0] hb;
    logic [VGA_MAX_V_WIDTH-1:0] vd;
    logic [VGA_MAX_V_WIDTH-1:0] vf;
    logic [VGA_MAX_V_WIDTH-1:0] vr;
    logic [VGA_MAX_V_WIDTH-1:0] vb;
  } vga_timing_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_LOAD,
    ST_ACK
  } vga_ctrl_state_e;

  localparam vga_timing_t VGA_MODES [VGA_TABLE_SIZE] = '{
    '{hd: 11'd640,  hf: 11'd16, hr: 11'd96,  hb: 11'd48,
      vd: 10'd480,  vf: 10'd10, vr: 10'd2,   vb: 10'd33},
    '{hd: 11'd800,  hf: 11'd40, hr: 11'd128, hb: 11'd88,
      vd: 10'd600,  vf: 10'd1,  vr: 10'd4,   vb: 10'd23},
    '{hd: 11'd1024, hf: 11'd24, hr: 11'd136, hb: 11'd160,
      vd: 10'd768,  vf: 10'd3,  vr: 10'd6,   vb: 10'd29},
    '{hd: 11'd8,    hf: 11'd2,  hr: 11'd2,   hb: 11'd2,
      vd: 10'd4,    vf: 10'd1,  vr: 10'd1,   vb: 10'd1}
  };

  // Last horizontal / vertical count of a frame (total minus one).
  function automatic logic [VGA_MAX_H_WIDTH-1:0] vga_hmax(input vga_timing_t t);
    return t.hd + t.hf + t.hr + t.hb - VGA_MAX_H_WIDTH'(1);
  endfunction

  function automatic logic [VGA_MAX_V_WIDTH-1:0] vga_vmax(input vga_timing_t t);
    return t.vd + t.vf + t.vr + t.vb - VGA_MAX_V_WIDTH'(1);
  endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode-index to timing-field lookup.
// Zero latency; no state.
module vga_mode_rom
  import vga_pkg::*;
(
  input  logic [VGA_MODE_W-1:0] i_idx,
  output vga_timing_t           o_timing
);

  assign o_timing = VGA_MODES[i_idx];

endmodule

// File: rtl/vga_mode_ctrl.sv
// Mode-switch controller: reprograms the timing generator only on the last pixel
// of a frame (or on watchdog expiry) and acknowledges each request exactly once.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_MODES   = 4,
  parameter int RESET_MODE  = 0,
  parameter int WDOG_CYCLES = 2**22
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic [VGA_MODE_W-1:0]      mode_i,
  input  logic                       mode_req_i,
  output logic                       mode_ack_o,
  output logic                       mode_err_o,
  output logic                       busy_o,
  input  logic [VGA_MAX_H_WIDTH-1:0] hcount_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] vcount_i,
  output logic [VGA_MAX_H_WIDTH-1:0] hd_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hf_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hr_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hb_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vd_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vf_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vr_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vb_o,
  output logic                       we_o,
  output logic [VGA_MODE_W-1:0]      cur_mode_o
);

  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [VGA_MODE_W-1:0] RESET_IDX    = VGA_MODE_W'(RESET_MODE);
  localparam vga_timing_t           RESET_TIMING = VGA_MODES[RESET_IDX];

  vga_ctrl_state_e       r_state;
  vga_ctrl_state_e       w_state_nxt;
  vga_timing_t           r_timing;
  vga_timing_t           w_rom_timing;
  logic [VGA_MODE_W-1:0] r_pend;
  logic [VGA_MODE_W-1:0] r_cur;
  logic [WDOG_W-1:0]     r_wdog;
  logic                  r_we;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_busy;

  logic                       w_latch;
  logic                       w_load;
  logic                       w_err_nxt;
  logic                       w_frame_hit;
  logic                       w_wdog_hit;
  logic [VGA_MAX_H_WIDTH-1:0] w_hmax_cur;
  logic [VGA_MAX_V_WIDTH-1:0] w_vmax_cur;

  vga_mode_rom u_rom (
    .i_idx    (r_pend),
    .o_timing (w_rom_timing)
  );

  assign w_hmax_cur = vga_hmax(r_timing);
  assign w_vmax_cur = vga_vmax(r_timing);

  // Registering on the second-to-last pixel puts the write strobe on the last one.
  assign w_frame_hit = (hcount_i == w_hmax_cur - VGA_MAX_H_WIDTH'(1)) &&
                       (vcount_i == w_vmax_cur);
  assign w_wdog_hit  = (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_INIT: w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (mode_req_i) begin
          if (32'(mode_i) >= 32'(NUM_MODES)) begin
            w_state_nxt = ST_ACK;
            w_err_nxt   = 1'b1;
          end else if (mode_i == r_cur) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_WAIT_FRAME;
          end
        end
      end
      ST_WAIT_FRAME: begin
        if (w_frame_hit || w_wdog_hit) begin
          w_load      = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state  <= ST_INIT;
      r_timing <= RESET_TIMING;
      r_cur    <= RESET_IDX;
      r_pend   <= RESET_IDX;
      r_wdog   <= '0;
      r_we     <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= (r_state == ST_INIT) || w_load;
      r_ack   <= (w_state_nxt == ST_ACK);
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_wdog  <= ((r_state == ST_WAIT_FRAME) && (w_state_nxt == ST_WAIT_FRAME)) ?
                 r_wdog + WDOG_W'(1) : '0;
      if (r_state == ST_INIT) begin
        r_timing <= RESET_TIMING;
        r_cur    <= RESET_IDX;
      end
      if (w_latch) begin
        r_pend <= mode_i;
      end
      if (w_load) begin
        r_timing <= w_rom_timing;
        r_cur    <= r_pend;
      end
    end
  end

  assign we_o       = r_we;
  assign mode_ack_o = r_ack;
  assign mode_err_o = r_err;
  assign busy_o     = r_busy;
  assign cur_mode_o = r_cur;
  assign hd_o       = r_timing.hd;
  assign hf_o       = r_timing.hf;
  assign hr_o       = r_timing.hr;
  assign hb_o       = r_timing.hb;
  assign vd_o       = r_timing.vd;
  assign vf_o       = r_timing.vf;
  assign vr_o       = r_timing.vr;
  assign vb_o       = r_timing.vb;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench: instance a has 4 modes and a long watchdog; instance b has 3 modes
// and a 64-cycle watchdog. Both reset into the small simulation mode (3).
module tb_vga_mode_ctrl;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a
  logic [1:0]  mode_a;
  logic        req_a;
  logic [10:0] hc_a;
  logic [9:0]  vc_a;
  logic        ack_a, err_a, busy_a, we_a;
  logic [1:0]  cur_a;
  logic [10:0] hd_a, hf_a, hr_a, hb_a;
  logic [9:0]  vd_a, vf_a, vr_a, vb_a;

  // Instance b
  logic [1:0]  mode_b;
  logic        req_b;
  logic [10:0] hc_b;
  logic [9:0]  vc_b;
  logic        ack_b, err_b, busy_b, we_b;
  logic [1:0]  cur_b;
  logic [10:0] hd_b, hf_b, hr_b, hb_b;
  logic [9:0]  vd_b, vf_b, vr_b, vb_b;

  logic gen_en;

  localparam logic [83:0] EXP_M3 = {11'd8, 11'd2, 11'd2, 11'd2, 10'd4, 10'd1, 10'd1, 10'd1};
  localparam logic [83:0] EXP_M0 = {11'd640, 11'd16, 11'd96, 11'd48,
                                    10'd480, 10'd10, 10'd2, 10'd33};

  vga_mode_ctrl #(.NUM_MODES(4), .RESET_MODE(3), .WDOG_CYCLES(200)) u_dut_a (
    .clk_i(clk), .arstn_i(arstn), .mode_i(mode_a), .mode_req_i(req_a),
    .mode_ack_o(ack_a), .mode_err_o(err_a), .busy_o(busy_a),
    .hcount_i(hc_a), .vcount_i(vc_a),
    .hd_o(hd_a), .hf_o(hf_a), .hr_o(hr_a), .hb_o(hb_a),
    .vd_o(vd_a), .vf_o(vf_a), .vr_o(vr_a), .vb_o(vb_a),
    .we_o(we_a), .cur_mode_o(cur_a)
  );

  vga_mode_ctrl #(.NUM_MODES(3), .RESET_MODE(3), .WDOG_CYCLES(64)) u_dut_b (
    .clk_i(clk), .arstn_i(arstn), .mode_i(mode_b), .mode_req_i(req_b),
    .mode_ack_o(ack_b), .mode_err_o(err_b), .busy_o(busy_b),
    .hcount_i(hc_b), .vcount_i(vc_b),
    .hd_o(hd_b), .hf_o(hf_b), .hr_o(hr_b), .hb_o(hb_b),
    .vd_o(vd_b), .vf_o(vf_b), .vr_o(vr_b), .vb_o(vb_b),
    .we_o(we_b), .cur_mode_o(cur_b)
  );

  wire [83:0] flds_a = {hd_a, hf_a, hr_a, hb_a, vd_a, vf_a, vr_a, vb_a};
  wire [83:0] flds_b = {hd_b, hf_b, hr_b, hb_b, vd_b, vf_b, vr_b, vb_b};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; instance a's counters model a generator running mode 3 (14 x 7).
  task automatic tick();
    @(posedge clk);
    #1;
    if (gen_en) begin
      if (hc_a == 11'd13) begin
        hc_a = '0;
        vc_a = (vc_a == 10'd6) ? 10'd0 : vc_a + 10'd1;
      end else begin
        hc_a = hc_a + 11'd1;
      end
    end
  endtask

  int n;
  int acks_seen;

  initial begin
    arstn  = 1'b0;
    gen_en = 1'b0;
    mode_a = 2'd0; req_a = 1'b0; hc_a = '0; vc_a = '0;
    mode_b = 2'd0; req_b = 1'b0; hc_b = '0; vc_b = '0;

    // Reset state
    #12;
    chk("rst_we",   we_a,   1'b0);
    chk("rst_ack",  ack_a,  1'b0);
    chk("rst_err",  err_a,  1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_cur",  cur_a,  2'd3);
    chk("rst_flds", flds_a, EXP_M3);

    // Reset release: INIT writes the reset mode once
    @(negedge clk);
    arstn = 1'b1;
    tick();
    chk("init_we",     we_a,   1'b1);
    chk("init_flds",   flds_a, EXP_M3);
    chk("init_we_b",   we_b,   1'b1);
    tick();
    chk("init_we_off", we_a,   1'b0);
    chk("init_busy",   busy_a, 1'b0);

    // Same-mode request: immediate ack, no load
    mode_a = 2'd3; req_a = 1'b1;
    tick();
    chk("same_ack", ack_a, 1'b1);
    chk("same_err", err_a, 1'b0);
    chk("same_we",  we_a,  1'b0);
    chk("same_cur", cur_a, 2'd3);
    req_a = 1'b0;
    tick();
    chk("same_ack_off", ack_a, 1'b0);

    // Out-of-range request on the 3-mode instance
    mode_b = 2'd3; req_b = 1'b1;
    tick();
    chk("bad_ack",  ack_b,  1'b1);
    chk("bad_err",  err_b,  1'b1);
    chk("bad_flds", flds_b, EXP_M3);
    chk("bad_cur",  cur_b,  2'd3);
    req_b = 1'b0;
    tick();
    chk("bad_ack_off", ack_b, 1'b0);

    // Frame-aligned switch 3 -> 0 with the generator running
    gen_en = 1'b1;
    mode_a = 2'd0; req_a = 1'b1;
    tick();
    chk("sw_busy", busy_a, 1'b1);
    mode_a = 2'd2;
    n = 0;
    while (!we_a && n < 300) begin
      tick();
      n++;
    end
    chk("sw_we_seen", we_a, 1'b1);
    chk("sw_hc",   hc_a,   11'd13);
    chk("sw_vc",   vc_a,   10'd6);
    chk("sw_flds", flds_a, EXP_M0);
    chk("sw_cur",  cur_a,  2'd0);
    tick();
    chk("sw_ack",    ack_a, 1'b1);
    chk("sw_err",    err_a, 1'b0);
    chk("sw_we_off", we_a,  1'b0);
    req_a = 1'b0;
    tick();
    chk("sw_idle", busy_a, 1'b0);
    chk("sw_cur_keep", cur_a, 2'd0);

    // Watchdog on instance b: counters frozen at 0
    mode_b = 2'd0; req_b = 1'b1;
    tick();
    n = 0;
    while (!we_b && n < 200) begin
      tick();
      n++;
    end
    chk("wd_cycles", n, 64);
    chk("wd_flds",   flds_b, EXP_M0);
    tick();
    chk("wd_ack", ack_b, 1'b1);
    chk("wd_err", err_b, 1'b0);
    req_b = 1'b0;
    tick();

    // Reset two cycles into WAIT_FRAME discards the pending request
    mode_a = 2'd1; req_a = 1'b1;
    tick();
    tick();
    tick();
    chk("rw_busy", busy_a, 1'b1);
    arstn = 1'b0;
    #1;
    chk("rw_rst_cur", cur_a, 2'd3);
    chk("rw_rst_we",  we_a,  1'b0);
    req_a = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    tick();
    chk("rw_init_we",   we_a,   1'b1);
    chk("rw_init_flds", flds_a, EXP_M3);
    acks_seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (ack_a || ack_b) acks_seen++;
    end
    chk("rw_no_ack", acks_seen, 0);
    chk("rw_cur",    cur_a,     2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
